// File: rtl/pipereg_elastic_pkg.sv
// Shared ROB index type and age comparison for the elastic pipeline register
// and other ROB-ordered structures.
package pipereg_elastic_pkg;

  localparam int ROB_W = 6;

  typedef struct packed {
    logic             flag;
    logic [ROB_W-1:0] idx;
  } robidx_t;

  // True when e was allocated after f, taking the wrap flag into account.
  function automatic logic is_younger(robidx_t e, robidx_t f);
    if (e.flag == f.flag) return e.idx > f.idx;
    else                  return e.idx < f.idx;
  endfunction

endpackage

// File: rtl/pipereg_elastic_if.sv
// Upstream, downstream and redirect signals of the elastic stage.
interface pipereg_elastic_if #(
  parameter int DATA_W = 64,
  parameter int ROB_W  = pipereg_elastic_pkg::ROB_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_robidx_flag;
  logic [ROB_W-1:0]  in_robidx;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_robidx_flag;
  logic [ROB_W-1:0]  out_robidx;
  logic              flush_valid;
  logic              flush_robidx_flag;
  logic [ROB_W-1:0]  flush_robidx;

  modport master (
    output in_valid, in_data, in_robidx_flag, in_robidx, out_ready,
           flush_valid, flush_robidx_flag, flush_robidx,
    input  in_ready, out_valid, out_data, out_robidx_flag, out_robidx
  );

  modport slave (
    input  in_valid, in_data, in_robidx_flag, in_robidx, out_ready,
           flush_valid, flush_robidx_flag, flush_robidx,
    output in_ready, out_valid, out_data, out_robidx_flag, out_robidx
  );

endinterface

// File: rtl/pipereg_elastic_rob_age_cmp.sv
// Flags whether ROB index a is younger than ROB index b.
module rob_age_cmp
  import pipereg_elastic_pkg::*;
(
  input  robidx_t a,
  input  robidx_t b,
  output logic    younger
);

  assign younger = is_younger(a, b);

endmodule

// File: rtl/pipereg_elastic.sv
// DEPTH-entry in-order elastic stage with registered in_ready and
// age-based selective redirect flush.
module pipereg_elastic #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int ROB_W  = pipereg_elastic_pkg::ROB_W,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  pipereg_elastic_if.slave bus,
  output logic [CNT_W-1:0] count
);

  import pipereg_elastic_pkg::*;

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int PKG_ROB_W = pipereg_elastic_pkg::ROB_W;

  logic [DATA_W-1:0] mem_data [DEPTH];
  robidx_t           mem_rob  [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt, push_ptr;
  logic [CNT_W-1:0] count_nxt, kept;
  logic [DEPTH-1:0] entry_younger, keep;
  logic             in_younger, in_fire, out_fire, do_push;
  logic             in_ready_int, out_valid_int;
  robidx_t          flush_pt, in_pt;

  function automatic logic [PTR_W-1:0] ptr_add(logic [PTR_W-1:0] p, int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  assign flush_pt = '{flag: bus.flush_robidx_flag, idx: PKG_ROB_W'(bus.flush_robidx)};
  assign in_pt    = '{flag: bus.in_robidx_flag,    idx: PKG_ROB_W'(bus.in_robidx)};

  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    rob_age_cmp u_cmp (.a(mem_rob[i]), .b(flush_pt), .younger(entry_younger[i]));
  end

  rob_age_cmp u_in_cmp (.a(in_pt), .b(flush_pt), .younger(in_younger));

  // in_ready depends only on the count register, never on out_ready.
  assign in_ready_int  = count < CNT_W'(DEPTH);
  assign out_valid_int = (count != '0) & ~bus.flush_valid;

  assign bus.in_ready        = in_ready_int;
  assign bus.out_valid       = out_valid_int;
  assign bus.out_data        = mem_data[rd_ptr];
  assign bus.out_robidx_flag = mem_rob[rd_ptr].flag;
  assign bus.out_robidx      = ROB_W'(mem_rob[rd_ptr].idx);

  // Survivors of a flush are a prefix from rd_ptr, so their popcount
  // is enough to rebuild both the count and the write pointer.
  always_comb begin
    int off;
    off  = 0;
    kept = '0;
    keep = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off     = (i >= int'(rd_ptr)) ? i - int'(rd_ptr) : i + DEPTH - int'(rd_ptr);
      keep[i] = (off < int'(count)) & ~entry_younger[i];
      kept    = kept + CNT_W'(keep[i]);
    end

    in_fire    = bus.in_valid & in_ready_int;
    out_fire   = out_valid_int & bus.out_ready;
    do_push    = in_fire & ~(bus.flush_valid & in_younger);
    push_ptr   = bus.flush_valid ? ptr_add(rd_ptr, int'(kept)) : wr_ptr;
    wr_ptr_nxt = do_push  ? ptr_add(push_ptr, 1) : push_ptr;
    rd_ptr_nxt = out_fire ? ptr_add(rd_ptr, 1)   : rd_ptr;
    count_nxt  = (bus.flush_valid ? kept : count) + CNT_W'(do_push) - CNT_W'(out_fire);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_data[push_ptr] <= bus.in_data;
      mem_rob[push_ptr]  <= in_pt;
    end
  end

endmodule
